// File: rtl/nv_ram_fifo_ctrl_512x32.sv
// nv_ram_fifo_ctrl_512x32
// Turns an external 512x32 two-port RAM into a 512-entry valid/ready FIFO.
// The RAM output register is the FIFO output stage: a word is "loaded" by
// latching its read address (ram_re), and is then presented on rd_pd until
// popped. The presented word still counts as occupied, so its RAM slot can
// never be overwritten while it is on display.
// Optional build macro NV_RAM_FIFO_CTRL_HWM_EN: when defined, fifo_hwm tracks
// the peak occupancy since reset or clr; otherwise fifo_hwm is tied to zero.
module nv_ram_fifo_ctrl_512x32 #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 32
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          clr,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW:0]   fifo_count,
    output logic [AW:0]   fifo_hwm,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    input  logic [DW-1:0] ram_dout,
    input  logic [31:0]   pwrbus_ram_pd
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Pointers carry an extra wrap bit at [AW]; only [AW-1:0] addresses the RAM.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic [AW:0] count_next;
    logic [AW:0] unl;
    logic        push;
    logic        pop;
    logic        load;
    logic        rd_pvld_next;
    logic        unused_bits;

    // Handshake decode, read-ahead decision and next-state for count/valid.
    always_comb begin
        push         = wr_pvld & wr_prdy & ~clr;
        pop          = rd_pvld & rd_prdy & ~clr;
        // Entries in RAM not yet moved into the output register.
        unl          = count - {{AW{1'b0}}, rd_pvld};
        // Load when something is waiting and the output slot is free or
        // being freed this cycle.
        load         = (unl != '0) & (~rd_pvld | rd_prdy) & ~clr;
        count_next   = count;
        rd_pvld_next = rd_pvld;
        if (clr) begin
            count_next   = '0;
            rd_pvld_next = 1'b0;
        end else begin
            count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (load) begin
                rd_pvld_next = 1'b1;
            end else if (pop) begin
                rd_pvld_next = 1'b0;
            end
        end
    end

    assign ram_we     = push;
    assign ram_wa     = wr_ptr[AW-1:0];
    assign ram_di     = wr_pd;
    assign ram_re     = load;
    assign ram_ra     = rd_ptr[AW-1:0];
    assign rd_pd      = ram_dout;
    assign fifo_count = count;

    // Control state: pointers, occupancy, output valid and registered ready.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_pvld <= 1'b0;
            wr_prdy <= 1'b0;
        end else begin
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (load) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            count   <= count_next;
            rd_pvld <= rd_pvld_next;
            // Ready is registered from next occupancy so a pop at full
            // reopens the write side on the following cycle.
            wr_prdy <= (count_next != FULL_CNT);
        end
    end

`ifdef NV_RAM_FIFO_CTRL_HWM_EN
    logic [AW:0] hwm;

    // Peak occupancy, updated on the same edge as count.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            hwm <= '0;
        end else if (clr) begin
            hwm <= '0;
        end else if (count_next > hwm) begin
            hwm <= count_next;
        end
    end

    assign fifo_hwm = hwm;
`else
    assign fifo_hwm = '0;
`endif

    // The RAM power bus and pointer wrap bits have no consumer here.
    assign unused_bits = ^{pwrbus_ram_pd, wr_ptr[AW], rd_ptr[AW]};

endmodule
